// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state encoding.
package mult_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StIssue = ISSUE,
        StWait  = WAIT,
        StResp  = RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned R    = 4,
    parameter int unsigned ID_W = $clog2(R)
) (
    input  logic [R-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [R-1:0]    gnt_o,
    output logic [ID_W-1:0] idx_o
);

    // Scan R positions starting at the pointer; first set request wins.
    always_comb begin
        int unsigned     cand;
        logic [ID_W-1:0] cidx;
        logic            found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < R; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= R) cand = cand - R;
            cidx = ID_W'(cand);
            if (!found && req_i[cidx]) begin
                found       = 1'b1;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential multiplier between R requesters with round-robin arbitration.
// One transaction in flight; the product returns tagged with the owning requester ID.
// Optional: MULT_SHARE_ZERO_BYPASS_EN answers zero-operand requests without the multiplier.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned R    = 4,
    parameter int unsigned ID_W = $clog2(R)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [R-1:0]      i_req_valid,
    output logic [R-1:0]      o_req_ready,
    input  logic [R*N-1:0]    i_req_a,
    input  logic [R*N-1:0]    i_req_b,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [2*N-1:0]    o_rsp_data,
    output logic [ID_W-1:0]   o_rsp_id,
    output logic              o_mul_start,
    output logic [N-1:0]      o_mul_multiplier,
    output logic [N-1:0]      o_mul_multiplicand,
    input  logic [2*N-1:0]    i_mul_result,
    input  logic              i_mul_finish
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [2*N-1:0]    data_q, data_d;

    logic [R-1:0]      gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic [N-1:0]      sel_a, sel_b;

    rr_arbiter #(
        .R    (R),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req_i (i_req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // One-hot operand mux driven by the grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < R; k++) begin
            if (gnt[k]) begin
                sel_a = i_req_a[k*N +: N];
                sel_b = i_req_b[k*N +: N];
            end
        end
    end

`ifdef MULT_SHARE_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`endif

    // Next-state, register updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        data_d      = data_q;
        o_req_ready = '0;
        o_mul_start = 1'b0;
        o_rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|i_req_valid) begin
                    o_req_ready = gnt;
                    a_d         = sel_a;
                    b_d         = sel_b;
                    id_d        = gnt_idx;
                    state_d     = StIssue;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
                    if (zero_op) begin
                        data_d  = '0;
                        state_d = StResp;
                    end
`endif
                end
            end
            StIssue: begin
                o_mul_start = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                if (i_mul_finish) begin
                    data_d  = i_mul_result;
                    state_d = StResp;
                end
            end
            StResp: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    ptr_d   = (id_q == ID_W'(R - 1)) ? '0 : id_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pointer and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
        end
    end

    assign o_rsp_data         = data_q;
    assign o_rsp_id           = id_q;
    assign o_mul_multiplier   = a_q;
    assign o_mul_multiplicand = b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier stub.
module tb_mult_share_arbiter;

    localparam int N   = 8;
    localparam int R   = 4;
    localparam int LAT = 2 * N + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [R-1:0]     req_valid = '0;
    logic [R-1:0]     req_ready;
    logic [R*N-1:0]   req_a = '0;
    logic [R*N-1:0]   req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [2*N-1:0]   rsp_data;
    logic [1:0]       rsp_id;
    logic             mul_start;
    logic [N-1:0]     mul_a;
    logic [N-1:0]     mul_b;
    logic [2*N-1:0]   mul_result = '0;
    logic             stub_fin = 1'b0;
    logic             spur_fin = 1'b0;

    int tests = 0;
    int fails = 0;

    mult_share_arbiter #(
        .N    (N),
        .R    (R),
        .ID_W (2)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_a            (req_a),
        .i_req_b            (req_b),
        .o_rsp_valid        (rsp_valid),
        .i_rsp_ready        (rsp_ready),
        .o_rsp_data         (rsp_data),
        .o_rsp_id           (rsp_id),
        .o_mul_start        (mul_start),
        .o_mul_multiplier   (mul_a),
        .o_mul_multiplicand (mul_b),
        .i_mul_result       (mul_result),
        .i_mul_finish       (stub_fin | spur_fin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    function automatic int rr_pick(input logic [R-1:0] v, input int p);
        for (int i = 0; i < R; i++) begin
            if (v[(p + i) % R]) return (p + i) % R;
        end
        return -1;
    endfunction

    // Multiplier stub: finish LAT cycles after the start cycle; garbage result otherwise.
    int stub_cnt = 0;
    logic [7:0] stub_a, stub_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            stub_cnt   = 0;
            stub_fin   = 1'b0;
            mul_result = 16'hBEEF;
        end else begin
            stub_fin   = 1'b0;
            mul_result = 16'hBEEF;
            if (mul_start) begin
                stub_cnt = LAT;
                stub_a   = mul_a;
                stub_b   = mul_b;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    stub_fin   = 1'b1;
                    mul_result = smul(stub_a, stub_b);
                end
            end
        end
    end

    // Transaction-level reference model and per-cycle comparison.
    int         cyc = 0;
    bit         inflight = 0;
    int         acc_cyc = 0;
    int         ptr_m = 0;
    int         m_id = 0;
    logic [7:0] m_a, m_b;
    logic [15:0] m_p;
    bit         m_byp = 0;
    int         grant_log[$];

    always @(negedge clk) begin
        logic [R-1:0] exp_rdy;
        bit exp_start, exp_valid;
        int g;
        if (!rst_n) begin
            inflight = 0;
            ptr_m    = 0;
        end else begin
            cyc++;
            exp_rdy = '0;
            g = -1;
            if (!inflight) begin
                g = rr_pick(req_valid, ptr_m);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            exp_start = inflight && !m_byp && (cyc == acc_cyc + 1);
            chk("mul_start", 32'(mul_start), 32'(exp_start));
            exp_valid = inflight && (cyc >= acc_cyc + (m_byp ? 1 : 2 + LAT));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (inflight && !m_byp && cyc > acc_cyc && !exp_valid) begin
                chk("mul_operands", {16'h0, mul_a, mul_b}, {16'h0, m_a, m_b});
            end
            if (exp_valid) begin
                chk("rsp_data", 32'(rsp_data), 32'(m_p));
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
            end
            if (exp_valid && rsp_ready) begin
                inflight = 0;
                ptr_m    = (m_id + 1) % R;
            end else if (g >= 0) begin
                inflight = 1;
                acc_cyc  = cyc;
                m_id     = g;
                m_a      = req_a[g*N +: N];
                m_b      = req_b[g*N +: N];
                m_p      = smul(m_a, m_b);
`ifdef MULT_SHARE_ZERO_BYPASS_EN
                m_byp    = (m_a == 8'h00) || (m_b == 8'h00);
`else
                m_byp    = 0;
`endif
                grant_log.push_back(g);
            end
        end
    end

    task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
        req_a[k*N +: N] = a;
        req_b[k*N +: N] = b;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (inflight && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (inflight) timeout("wait_idle");
    endtask

    // Issue one request from requester k and capture its response.
    task automatic single(input int k, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] data, output int id);
        int n = 0;
        data = 'x;
        id = -1;
        @(posedge clk); #1;
        set_ops(k, a, b);
        req_valid[k] = 1'b1;
        @(negedge clk);
        while (req_ready == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == '0) timeout("single_grant");
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) timeout("single_rsp");
        data = rsp_data;
        id = int'(rsp_id);
        wait_idle();
    endtask

    // Hold the request mask until cnt more grants have been made, then drop it.
    task automatic burst(input logic [R-1:0] mask, input int cnt);
        int base = grant_log.size();
        int n = 0;
        @(posedge clk); #1;
        req_valid = mask;
        @(negedge clk);
        while (grant_log.size() < base + cnt && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (grant_log.size() < base + cnt) timeout("burst_grants");
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
    endtask

    logic [15:0] d;
    int          id;
    int          base;
    logic [15:0] bp_first;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_mul", {15'h0, mul_start, mul_a, mul_b}, 32'h0);
        rst_n = 1'b1;

        // Single request: 3 * -5.
        single(0, 8'd3, 8'hFB, d, id);
        chk("single_data", 32'(d), 32'h0000FFF1);
        chk("single_id", 32'(id), 32'd0);

        // Pointer back to 0, then all four requesters continuously.
        single(3, 8'hFF, 8'hFF, d, id);
        chk("neg_neg_data", 32'(d), 32'h00000001);
        for (int k = 0; k < R; k++) set_ops(k, 8'(k + 2), 8'(-(k + 1)));
        base = grant_log.size();
        burst(4'hF, 5);
        chk("order0", 32'(grant_log[base]), 32'd0);
        chk("order1", 32'(grant_log[base + 1]), 32'd1);
        chk("order2", 32'(grant_log[base + 2]), 32'd2);
        chk("order3", 32'(grant_log[base + 3]), 32'd3);
        chk("order4", 32'(grant_log[base + 4]), 32'd0);

        // Extreme operands; leaves pointer at 3.
        single(2, 8'h80, 8'h80, d, id);
        chk("min_min_data", 32'(d), 32'h00004000);

        // Pointer 3 with only req1 valid -> grant 1, pointer then 2.
        single(1, 8'hFF, 8'h02, d, id);
        chk("ptr3_req1_id", 32'(id), 32'd1);
        chk("ptr3_req1_data", 32'(d), 32'h0000FFFE);
        base = grant_log.size();
        burst(4'hE, 1);
        chk("ptr_after_1", 32'(grant_log[base]), 32'd2);

        // Pointer 3 with only req0 valid -> wrap to 0.
        single(0, 8'h7F, 8'h80, d, id);
        chk("wrap_id", 32'(id), 32'd0);
        chk("wrap_data", 32'(d), 32'h0000C080);

        // Zero operand (bypassed when the option is built in).
        single(1, 8'h00, 8'd7, d, id);
        chk("zero_data", 32'(d), 32'h00000000);

        // Backpressure with a competing request and a stray finish pulse.
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_ops(2, 8'h10, 8'h10);
        req_valid[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        req_valid[3] = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!rsp_valid) timeout("bp_rsp");
        end
        bp_first = rsp_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            spur_fin = (i == 4);
        end
        spur_fin = 1'b0;
        @(negedge clk);
        chk("bp_first_data", 32'(bp_first), 32'h00000100);
        chk("bp_last_data", 32'(rsp_data), 32'h00000100);
        chk("bp_last_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid[3] = 1'b0;
        wait_idle();

        // Reset while waiting on the multiplier.
        @(posedge clk); #1;
        set_ops(3, 8'd6, 8'd7);
        req_valid[3] = 1'b1;
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_wait_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_wait_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_wait_mul", {15'h0, mul_start, mul_a, mul_b}, 32'h0);
        chk("rst_wait_ready", 32'(req_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        single(3, 8'd6, 8'd7, d, id);
        chk("after_rst_data", 32'(d), 32'h0000002A);
        chk("after_rst_id", 32'(id), 32'd3);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
